// File: rtl/tlb_pkg.sv
// Shared definitions for the TLB refill engine: default geometry, derived
// widths, PTE flag positions and the page-walk FSM states.
package tlb_pkg;

   localparam int DEF_SADDR = 64;
   localparam int DEF_SPAGE = 12;
   localparam int DEF_NSET  = 8;
   localparam int DEF_SPCID = 12;
   localparam int DEF_NWAY  = 8;
   localparam int DEF_NLVL  = 3;
   localparam int DEF_SIDX  = 9;

   localparam int SET_W = $clog2(DEF_NSET);
   localparam int WAY_W = $clog2(DEF_NWAY);
   localparam int TAG_W = DEF_SADDR - WAY_W;
   localparam int PPN_W = DEF_SADDR - DEF_SPAGE;

   localparam int PTE_V    = 0;
   localparam int PTE_LEAF = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_FILL,
      ST_FAULT
   } walk_state_e;

endpackage

// File: rtl/tlb_rr_victim.sv
// Per-set round-robin victim pointers; the addressed pointer advances by one
// (wrapping at NWAY) on each fill strobe.
module tlb_rr_victim #(
   parameter int NSET = 8,
   parameter int NWAY = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [$clog2(NSET)-1:0] set_i,
   input  logic                    adv_i,
   output logic [$clog2(NWAY)-1:0] way_o
);

   localparam int WAY_BITS = $clog2(NWAY);

   logic [WAY_BITS-1:0] rr_q [NSET];

   assign way_o = rr_q[set_i];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NSET; i++) begin
            rr_q[i] <= '0;
         end
      end else if (adv_i) begin
         rr_q[set_i] <= rr_q[set_i] + WAY_BITS'(1);
      end
   end

endmodule

// File: rtl/tlb_fill.sv
// TLB refill engine: walks the radix page table on a miss and writes the
// resulting translation into the round-robin victim way of the target set.
module tlb_fill
   import tlb_pkg::*;
#(
   parameter int SADDR = DEF_SADDR,
   parameter int SPAGE = DEF_SPAGE,
   parameter int NSET  = DEF_NSET,
   parameter int SPCID = DEF_SPCID,
   parameter int NWAY  = DEF_NWAY,
   parameter int NLVL  = DEF_NLVL,
   parameter int SIDX  = DEF_SIDX
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             miss_valid,
   output logic                             miss_ready,
   input  logic [SADDR-1:0]                 miss_va,
   input  logic [SPCID-1:0]                 miss_pcid,
   input  logic [SADDR-SPAGE-1:0]           ptbr,
   output logic                             mem_req_valid,
   input  logic                             mem_req_ready,
   output logic [SADDR-1:0]                 mem_req_addr,
   input  logic                             mem_rsp_valid,
   input  logic [SADDR-1:0]                 mem_rsp_data,
   output logic                             fill_valid,
   output logic [$clog2(NSET)-1:0]          fill_set,
   output logic [$clog2(NWAY)-1:0]          fill_way,
   output logic [SADDR-$clog2(NWAY)-1:0]    fill_tag,
   output logic [SPCID-1:0]                 fill_pcid,
   output logic [SADDR-SPAGE-1:0]           fill_pa,
   output logic                             fault_valid,
   output logic [SADDR-1:0]                 fault_va
);

   localparam int SET_BITS = $clog2(NSET);
   localparam int WAY_BITS = $clog2(NWAY);
   localparam int TAG_BITS = SADDR - WAY_BITS;
   localparam int PPN_BITS = SADDR - SPAGE;
   localparam int LVL_BITS = (NLVL > 1) ? $clog2(NLVL) : 1;
   localparam logic [LVL_BITS-1:0] LVL_LAST = LVL_BITS'(NLVL - 1);

   walk_state_e          state_q, state_d;
   logic [LVL_BITS-1:0]  lvl_q, lvl_d;
   logic [SADDR-1:0]     va_q, va_d;
   logic [SPCID-1:0]     pcid_q, pcid_d;
   logic [PPN_BITS-1:0]  ppn_q, ppn_d;
   logic [SIDX-1:0]      idx;
   logic [SADDR-1:0]     req_addr;
   logic [PPN_BITS-1:0]  pte_ppn;
   logic [SET_BITS-1:0]  tgt_set;
   logic [WAY_BITS-1:0]  victim_way;
   logic                 rr_adv;
   logic                 unused_pte_bits;

   function automatic logic [SIDX-1:0] lvl_index(input logic [SADDR-1:0] va,
                                                 input logic [LVL_BITS-1:0] lvl);
      int sh;
      sh = SPAGE + SIDX * (NLVL - 1 - int'(lvl));
      return SIDX'(va >> sh);
   endfunction

   assign idx      = lvl_index(va_q, lvl_q);
   assign req_addr = {ppn_q, {SPAGE{1'b0}}} + {{(SADDR-SIDX-3){1'b0}}, idx, 3'b000};
   assign pte_ppn  = mem_rsp_data[SADDR-1:SPAGE];
   assign tgt_set  = va_q[SPAGE +: SET_BITS];

   // Flag bits between LEAF and the PPN carry no meaning for the walk.
   assign unused_pte_bits = ^mem_rsp_data[SPAGE-1:PTE_LEAF+1];

   tlb_rr_victim #(
      .NSET (NSET),
      .NWAY (NWAY)
   ) u_rr (
      .clk   (clk),
      .rst   (rst),
      .set_i (tgt_set),
      .adv_i (rr_adv),
      .way_o (victim_way)
   );

   always_comb begin
      state_d = state_q;
      lvl_d   = lvl_q;
      va_d    = va_q;
      pcid_d  = pcid_q;
      ppn_d   = ppn_q;
      rr_adv  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (miss_valid) begin
               va_d    = miss_va;
               pcid_d  = miss_pcid;
               ppn_d   = ptbr;
               lvl_d   = '0;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_req_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_rsp_valid) begin
               if (!mem_rsp_data[PTE_V]) begin
                  state_d = ST_FAULT;
               end else if (mem_rsp_data[PTE_LEAF]) begin
                  ppn_d   = pte_ppn;
                  state_d = ST_FILL;
               end else if (lvl_q != LVL_LAST) begin
                  ppn_d   = pte_ppn;
                  lvl_d   = lvl_q + LVL_BITS'(1);
                  state_d = ST_REQ;
               end else begin
                  state_d = ST_FAULT;
               end
            end
         end
         ST_FILL: begin
            rr_adv  = 1'b1;
            state_d = ST_IDLE;
         end
         ST_FAULT: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         lvl_q   <= '0;
      end else begin
         state_q <= state_d;
         lvl_q   <= lvl_d;
      end
   end

   // Walk context is only observed through state-gated outputs, so it needs no reset.
   always_ff @(posedge clk) begin
      va_q   <= va_d;
      pcid_q <= pcid_d;
      ppn_q  <= ppn_d;
   end

   assign miss_ready    = (state_q == ST_IDLE);
   assign mem_req_valid = (state_q == ST_REQ);
   assign mem_req_addr  = (state_q == ST_REQ) ? req_addr : '0;

   assign fill_valid = (state_q == ST_FILL);
   assign fill_set   = (state_q == ST_FILL) ? tgt_set : '0;
   assign fill_way   = (state_q == ST_FILL) ? victim_way : '0;
   assign fill_tag   = (state_q == ST_FILL) ? {{(TAG_BITS-PPN_BITS){1'b0}}, va_q[SADDR-1:SPAGE]} : '0;
   assign fill_pcid  = (state_q == ST_FILL) ? pcid_q : '0;
   assign fill_pa    = (state_q == ST_FILL) ? ppn_q : '0;

   assign fault_valid = (state_q == ST_FAULT);
   assign fault_va    = (state_q == ST_FAULT) ? va_q : '0;

endmodule
